// File: rtl/ppu_bg_fetch_if.sv
// rtl/ppu_bg_fetch_if.sv - PPU read port between the background fetcher and the memory manager
// The fetcher drives address/request; the memory side returns the read byte.
interface ppu_bg_fetch_if;
  logic [13:0] ppu_addr;
  logic        ppu_read_request;
  logic [7:0]  mem_rdata;

  modport master (output ppu_addr, output ppu_read_request, input mem_rdata);
  modport slave  (input ppu_addr, input ppu_read_request, output mem_rdata);
endinterface

// File: rtl/ppu_bg_fetch.sv
// rtl/ppu_bg_fetch.sv - PPU background tile fetch sequencer and pixel shifters
// Issues NT/AT/PT reads per dot, loads 16-bit shifters and emits one bg pixel per visible dot.
module ppu_bg_fetch #(
  parameter int VISIBLE_LINES  = 240,
  parameter int PRERENDER_LINE = 261
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_dot_en,
  input  logic [8:0]     i_dot,
  input  logic [8:0]     i_line,
  input  logic           i_render_en,
  input  logic           i_show_left_bg,
  input  logic           i_bg_pt_sel,
  input  logic [2:0]     i_fine_x,
  input  logic [14:0]    i_vram_v,
  ppu_bg_fetch_if.master mem,
  output logic           o_inc_hori,
  output logic           o_inc_vert,
  output logic           o_copy_hori,
  output logic [3:0]     o_bg_pixel,
  output logic           o_bg_pixel_valid
);
  localparam logic [8:0] L_VIS = 9'(VISIBLE_LINES);
  localparam logic [8:0] L_PRE = 9'(PRERENDER_LINE);

  logic [7:0]  r_nt_byte, r_pt_lo, r_pt_hi;
  logic [1:0]  r_at_bits, r_kind;
  logic        r_dummy;
  logic [15:0] r_sh_lo, r_sh_hi, r_sh_alo, r_sh_ahi;

  logic [2:0]  w_p;
  logic        w_visible, w_fetch_line, w_fetch_win, w_dummy, w_issue;
  logic        w_shift, w_reload, w_pix_dot, w_blank;
  logic [13:0] w_addr;
  logic [7:0]  w_at_sh;
  logic [15:0] w_lo_nxt, w_hi_nxt, w_alo_nxt, w_ahi_nxt;
  logic [3:0]  w_idx;
  logic [1:0]  w_pat, w_pal;

  assign w_p          = i_dot[2:0];
  assign w_visible    = i_line < L_VIS;
  assign w_fetch_line = i_render_en & (w_visible | (i_line == L_PRE));
  assign w_fetch_win  = (i_dot >= 9'd1 && i_dot <= 9'd256) || (i_dot >= 9'd321 && i_dot <= 9'd336);
  assign w_dummy      = (i_dot == 9'd337) || (i_dot == 9'd339);
  assign w_issue      = w_fetch_line & ((w_fetch_win & w_p[0]) | w_dummy);
  assign w_shift      = w_fetch_line & ((i_dot >= 9'd2 && i_dot <= 9'd257) ||
                                        (i_dot >= 9'd322 && i_dot <= 9'd337));
  assign w_reload     = w_fetch_line & (w_p == 3'd1) &
                        ((i_dot >= 9'd9 && i_dot <= 9'd257) || i_dot == 9'd329 || i_dot == 9'd337);
  assign w_pix_dot    = w_visible & (i_dot >= 9'd1) & (i_dot <= 9'd256);
  assign w_at_sh      = mem.mem_rdata >> {i_vram_v[6], i_vram_v[1], 1'b0};

  // Dummy fetches at 337/339 always address the nametable, whatever the phase.
  always_comb begin
    w_addr = {2'b10, i_vram_v[11:0]};
    if (!w_dummy) begin
      case (w_p[2:1])
        2'd1:    w_addr = {2'b10, i_vram_v[11:10], 4'b1111, i_vram_v[9:7], i_vram_v[4:2]};
        2'd2:    w_addr = {1'b0, i_bg_pt_sel, r_nt_byte, 1'b0, i_vram_v[14:12]};
        2'd3:    w_addr = {1'b0, i_bg_pt_sel, r_nt_byte, 1'b1, i_vram_v[14:12]};
        default: w_addr = {2'b10, i_vram_v[11:0]};
      endcase
    end
  end

  always_comb begin
    w_lo_nxt  = r_sh_lo;
    w_hi_nxt  = r_sh_hi;
    w_alo_nxt = r_sh_alo;
    w_ahi_nxt = r_sh_ahi;
    if (w_shift) begin
      w_lo_nxt  = {r_sh_lo[14:0], 1'b0};
      w_hi_nxt  = {r_sh_hi[14:0], 1'b0};
      w_alo_nxt = {r_sh_alo[14:0], 1'b0};
      w_ahi_nxt = {r_sh_ahi[14:0], 1'b0};
    end
    if (w_reload) begin
      w_lo_nxt[7:0]  = r_pt_lo;
      w_hi_nxt[7:0]  = r_pt_hi;
      w_alo_nxt[7:0] = {8{r_at_bits[0]}};
      w_ahi_nxt[7:0] = {8{r_at_bits[1]}};
    end
  end

  // The pixel is taken from the post-shift value so dot 1 shows bit 15 unshifted.
  assign w_idx   = 4'd15 - {1'b0, i_fine_x};
  assign w_pat   = {w_hi_nxt[w_idx], w_lo_nxt[w_idx]};
  assign w_pal   = {w_ahi_nxt[w_idx], w_alo_nxt[w_idx]};
  assign w_blank = !i_render_en | (!i_show_left_bg & (i_dot <= 9'd8)) | (w_pat == 2'b00) | !w_pix_dot;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem.ppu_addr         <= '0;
      mem.ppu_read_request <= 1'b0;
      r_kind               <= '0;
      r_dummy              <= 1'b0;
      r_nt_byte            <= '0;
      r_at_bits            <= '0;
      r_pt_lo              <= '0;
      r_pt_hi              <= '0;
      r_sh_lo              <= '0;
      r_sh_hi              <= '0;
      r_sh_alo             <= '0;
      r_sh_ahi             <= '0;
      o_inc_hori           <= 1'b0;
      o_inc_vert           <= 1'b0;
      o_copy_hori          <= 1'b0;
      o_bg_pixel           <= '0;
      o_bg_pixel_valid     <= 1'b0;
    end else begin
      o_inc_hori  <= i_dot_en & w_fetch_line & w_fetch_win & (w_p == 3'd0);
      o_inc_vert  <= i_dot_en & w_fetch_line & (i_dot == 9'd256);
      o_copy_hori <= i_dot_en & w_fetch_line & (i_dot == 9'd257);
      if (i_dot_en) begin
        mem.ppu_read_request <= w_issue;
        if (w_issue) mem.ppu_addr <= w_addr;
        r_kind  <= w_p[2:1];
        r_dummy <= w_dummy;
        if (w_fetch_line && mem.ppu_read_request && !r_dummy) begin
          case (r_kind)
            2'd0:    r_nt_byte <= mem.mem_rdata;
            2'd1:    r_at_bits <= w_at_sh[1:0];
            2'd2:    r_pt_lo   <= mem.mem_rdata;
            default: r_pt_hi   <= mem.mem_rdata;
          endcase
        end
        r_sh_lo          <= w_lo_nxt;
        r_sh_hi          <= w_hi_nxt;
        r_sh_alo         <= w_alo_nxt;
        r_sh_ahi         <= w_ahi_nxt;
        o_bg_pixel_valid <= w_pix_dot;
        o_bg_pixel       <= w_blank ? 4'h0 : {w_pal, w_pat};
      end
    end
  end
endmodule

// File: tb/tb_ppu_bg_fetch.sv
// tb/tb_ppu_bg_fetch.sv - directed self-checking bench for ppu_bg_fetch
// Dots are driven as one-clk dot_en strobes followed by one idle clk.
module tb_ppu_bg_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_dot_en, i_render_en, i_show_left_bg, i_bg_pt_sel;
  logic [8:0]  i_dot, i_line;
  logic [2:0]  i_fine_x;
  logic [14:0] i_vram_v;
  logic        o_inc_hori, o_inc_vert, o_copy_hori, o_bg_pixel_valid;
  logic [3:0]  o_bg_pixel;

  ppu_bg_fetch_if bus();

  ppu_bg_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .i_dot_en         (i_dot_en),
    .i_dot            (i_dot),
    .i_line           (i_line),
    .i_render_en      (i_render_en),
    .i_show_left_bg   (i_show_left_bg),
    .i_bg_pt_sel      (i_bg_pt_sel),
    .i_fine_x         (i_fine_x),
    .i_vram_v         (i_vram_v),
    .mem              (bus.master),
    .o_inc_hori       (o_inc_hori),
    .o_inc_vert       (o_inc_vert),
    .o_copy_hori      (o_copy_hori),
    .o_bg_pixel       (o_bg_pixel),
    .o_bg_pixel_valid (o_bg_pixel_valid)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] NT_B = 8'h24, AT_B = 8'hE4, LO_B = 8'hF0, HI_B = 8'hAA;

  int total = 0, bad = 0;
  int req_cnt, ih_cnt, iv_cnt, iv_dot, ch_cnt, ch_dot, val_cnt;
  logic        req_log  [0:340];
  logic        hold_log [0:340];
  logic        val_log  [0:340];
  logic [13:0] addr_log [0:340];
  logic [3:0]  pix_log  [0:340];

  function automatic logic [7:0] mem_lookup(input logic [13:0] a);
    if (a[13]) return (a[9:6] == 4'hF) ? AT_B : NT_B;
    return a[3] ? HI_B : LO_B;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int d, input int l);
    @(negedge clk);
    i_dot = 9'(d); i_line = 9'(l); i_dot_en = 1'b1;
    @(negedge clk);
    i_dot_en = 1'b0;
    req_log[d] = bus.ppu_read_request; addr_log[d] = bus.ppu_addr;
    pix_log[d] = o_bg_pixel; val_log[d] = o_bg_pixel_valid;
    if (bus.ppu_read_request) begin req_cnt++; bus.mem_rdata = mem_lookup(bus.ppu_addr); end
    if (o_inc_hori) ih_cnt++;
    if (o_inc_vert) begin iv_cnt++; iv_dot = d; end
    if (o_copy_hori) begin ch_cnt++; ch_dot = d; end
    if (o_bg_pixel_valid) val_cnt++;
    @(negedge clk);
    hold_log[d] = bus.ppu_read_request;
  endtask

  task automatic run(input int l, input int d0, input int d1);
    req_cnt = 0; ih_cnt = 0; iv_cnt = 0; iv_dot = -1; ch_cnt = 0; ch_dot = -1; val_cnt = 0;
    for (int d = d0; d <= d1; d++) step(d, l);
  endtask

  initial begin
    logic [3:0] exp_a [0:3];
    logic [3:0] exp_b [0:3];
    logic [3:0] exp_c [0:3];
    exp_a[0] = 4'h3; exp_a[1] = 4'h1; exp_a[2] = 4'h3; exp_a[3] = 4'h1;
    exp_b[0] = 4'h1; exp_b[1] = 4'h2; exp_b[2] = 4'h0; exp_b[3] = 4'h2;
    exp_c[0] = 4'h7; exp_c[1] = 4'h5; exp_c[2] = 4'h0; exp_c[3] = 4'h6;

    rst = 1'b1; i_dot_en = 1'b0; i_dot = '0; i_line = '0; i_render_en = 1'b0;
    i_show_left_bg = 1'b1; i_bg_pt_sel = 1'b1; i_fine_x = '0; i_vram_v = '0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req",   32'(bus.ppu_read_request), 32'd0);
    check("rst_addr",  32'(bus.ppu_addr), 32'd0);
    check("rst_pixel", 32'(o_bg_pixel), 32'd0);
    check("rst_valid", 32'(o_bg_pixel_valid), 32'd0);
    check("rst_pulse", 32'({o_inc_hori, o_inc_vert, o_copy_hori}), 32'd0);
    rst = 1'b0;

    // reset in the middle of an outstanding NT fetch
    i_render_en = 1'b1;
    step(1, 0);
    check("t1_req_pre", 32'(req_log[1]), 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_req_rst",  32'(bus.ppu_read_request), 32'd0);
    check("t1_addr_rst", 32'(bus.ppu_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t1_req_post", 32'(bus.ppu_read_request), 32'd0);

    // full pre-render line
    run(261, 0, 340);
    check("pre_req_cnt",  32'(req_cnt), 32'd138);
    check("pre_ih_cnt",   32'(ih_cnt), 32'd34);
    check("pre_iv_cnt",   32'(iv_cnt), 32'd1);
    check("pre_iv_dot",   32'(iv_dot), 32'd256);
    check("pre_ch_cnt",   32'(ch_cnt), 32'd1);
    check("pre_ch_dot",   32'(ch_dot), 32'd257);
    check("pre_valid",    32'(val_cnt), 32'd0);
    check("pre_addr321",  32'(addr_log[321]), 32'h2000);
    check("pre_addr327",  32'(addr_log[327]), 32'h1248);
    check("pre_dummy337", 32'({req_log[337], addr_log[337]}), 32'h6000);
    check("pre_dummy339", 32'({req_log[339], addr_log[339]}), 32'h6000);
    check("pre_req340",   32'(req_log[340]), 32'd0);

    // line 0, left 8 blanked, fine_x 0
    i_show_left_bg = 1'b0;
    for (int d = 0; d <= 8; d++) step(d, 0);
    i_show_left_bg = 1'b1;
    for (int d = 9; d <= 12; d++) step(d, 0);
    check("l0_addr_nt", 32'(addr_log[1]), 32'h2000);
    check("l0_addr_at", 32'(addr_log[3]), 32'h23C0);
    check("l0_addr_lo", 32'(addr_log[5]), 32'h1240);
    check("l0_addr_hi", 32'(addr_log[7]), 32'h1248);
    check("l0_hold1",   32'(hold_log[1]), 32'd1);
    check("l0_valid0",  32'(val_log[0]), 32'd0);
    check("l0_valid1",  32'(val_log[1]), 32'd1);
    check("l0_pix1",    32'(pix_log[1]), 32'd0);
    check("l0_valid8",  32'(val_log[8]), 32'd1);
    check("l0_pix8",    32'(pix_log[8]), 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("l0_pix%0d", 9 + k), 32'(pix_log[9 + k]), 32'(exp_a[k]));

    // same data with fine_x = 3
    i_fine_x = 3'd3;
    run(261, 321, 340);
    for (int d = 0; d <= 12; d++) step(d, 0);
    check("fx3_pix1", 32'(pix_log[1]), 32'd1);
    for (int k = 0; k < 4; k++) check($sformatf("fx3_pix%0d", 9 + k), 32'(pix_log[9 + k]), 32'(exp_b[k]));

    // v[1]=1 selects attribute palette 1
    i_vram_v = 15'h0002; i_fine_x = 3'd0;
    run(261, 321, 340);
    for (int d = 0; d <= 10; d++) step(d, 0);
    i_fine_x = 3'd3;
    step(11, 0);
    step(12, 0);
    check("pal_addr_nt", 32'(addr_log[1]), 32'h2002);
    for (int k = 0; k < 4; k++) check($sformatf("pal_pix%0d", 9 + k), 32'(pix_log[9 + k]), 32'(exp_c[k]));

    // render_en dropping mid-fetch
    step(13, 0);
    check("drop_req13",  32'({req_log[13], addr_log[13]}), 32'h5240);
    i_render_en = 1'b0;
    step(14, 0);
    check("drop_req14",  32'(req_log[14]), 32'd0);
    check("drop_pix14",  32'(pix_log[14]), 32'd0);
    check("drop_val14",  32'(val_log[14]), 32'd1);

    // idle line 240
    i_render_en = 1'b1;
    step(1, 240);
    check("idle_req", 32'(req_log[1]), 32'd0);
    check("idle_val", 32'(val_log[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
